// File: rtl/usbdev_remote_wake.sv
// rtl/usbdev_remote_wake.sv - USB device remote-wakeup resume (K) signalling generator
module usbdev_remote_wake #(
    parameter logic [15:0] IdleWaitUs       = 16'd5000,
    parameter logic [15:0] KDriveUs         = 16'd2000,
    parameter logic [15:0] ReleaseTimeoutUs = 16'd20000
) (
    input  logic clk_48mhz_i,
    input  logic rst_ni,
    input  logic us_tick_i,
    input  logic wake_req_i,
    input  logic link_powered_i,
    input  logic link_suspend_i,
    input  logic link_reset_i,
    output logic tx_oe_o,
    output logic tx_dp_o,
    output logic tx_dn_o,
    output logic wake_busy_o,
    output logic wake_done_o,
    output logic wake_aborted_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_DRIVE_K,
        ST_RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] susp_tmr_q, susp_tmr_d;
    logic [15:0] phase_tmr_q, phase_tmr_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        link_ok;

    assign link_ok = link_powered_i && !link_reset_i;

    // Suspend idle time accrues independently of the FSM so time spent
    // suspended before the request counts toward the minimum idle.
    always_comb begin
        susp_tmr_d = susp_tmr_q;
        if (!link_suspend_i) begin
            susp_tmr_d = 16'd0;
        end else if (us_tick_i && (susp_tmr_q != IdleWaitUs)) begin
            susp_tmr_d = susp_tmr_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if ((state_q != ST_IDLE) && !link_ok) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wake_req_i) begin
                        if (link_suspend_i && link_ok) begin
                            state_d = ST_WAIT_IDLE;
                        end else begin
                            aborted_d = 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!link_suspend_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (susp_tmr_q == IdleWaitUs) begin
                        state_d = ST_DRIVE_K;
                    end
                end
                ST_DRIVE_K: begin
                    if (us_tick_i && (phase_tmr_q == KDriveUs - 16'd1)) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!link_suspend_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (us_tick_i && (phase_tmr_q == ReleaseTimeoutUs - 16'd1)) begin
                        state_d   = ST_IDLE;
                        aborted_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        phase_tmr_d = phase_tmr_q;
        if (state_d != state_q) begin
            phase_tmr_d = 16'd0;
        end else if (us_tick_i) begin
            phase_tmr_d = phase_tmr_q + 16'd1;
        end
    end

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            susp_tmr_q  <= 16'd0;
            phase_tmr_q <= 16'd0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            susp_tmr_q  <= susp_tmr_d;
            phase_tmr_q <= phase_tmr_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Full-speed K: D+ low, D- high; both lines low whenever not driving.
    assign tx_oe_o        = (state_q == ST_DRIVE_K);
    assign tx_dp_o        = 1'b0;
    assign tx_dn_o        = tx_oe_o;
    assign wake_busy_o    = (state_q != ST_IDLE);
    assign wake_done_o    = done_q;
    assign wake_aborted_o = aborted_q;

endmodule
